// File: rtl/parity_link_pkg.sv
// Shared definitions for both ends of the 3-bit parity link: frame geometry,
// receiver states and the reference parity function.
package parity_link_pkg;

   localparam int FRAME_BITS = 4;
   localparam int DATA_BITS  = 3;

   typedef enum logic {
      IDLE,
      RECV
   } state_e;

   // Even-parity bit the transmitter appends after d0, d1, d2.
   function automatic logic parity3(input logic [DATA_BITS-1:0] d);
      return d[0] ^ d[1] ^ d[2];
   endfunction

endpackage

// File: rtl/parity_frame_checker_if.sv
// Serial input lines and decoded output lines of the parity link receiver,
// all carried as 32-bit words like the rest of the design.
interface parity_frame_checker_if;

   logic [31:0] signal_0;
   logic [31:0] signal_1;
   logic [31:0] signal_2;
   logic [31:0] signal_A;
   logic [31:0] signal_B;
   logic [31:0] signal_C;
   logic [31:0] signal_D;

   modport master (
      output signal_0, signal_1, signal_2,
      input  signal_A, signal_B, signal_C, signal_D
   );

   modport slave (
      input  signal_0, signal_1, signal_2,
      output signal_A, signal_B, signal_C, signal_D
   );

endinterface

// File: rtl/parity_lut3.sv
// Combinational 3-input odd-parity table: odd_o is 1 when an odd number of
// the inputs are set.
module parity_lut3 (
   input  logic [2:0] d_i,
   output logic       odd_o
);

   always_comb begin
      odd_o = 1'b0;
      case (d_i)
         3'b001, 3'b010, 3'b100, 3'b111: odd_o = 1'b1;
         default:                        odd_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/parity_frame_checker.sv
// Receiver for the 3-bit parity link: collects d0, d1, d2, p from a strobed
// serial line, checks parity and reports the word or a saturating error count.
module parity_frame_checker
   import parity_link_pkg::*;
#(
   parameter int TIMEOUT = 8,
   parameter int ERR_MAX = 255
) (
   input  logic                        clk,
   input  logic                        rst_n,
   parity_frame_checker_if.slave       bus
);

   localparam int               CNT_W     = $clog2(FRAME_BITS);
   localparam logic [CNT_W-1:0] LAST_POS  = CNT_W'(DATA_BITS);
   localparam logic [7:0]       TIMEOUT_W = 8'(TIMEOUT);
   localparam logic [31:0]      ERR_MAX_W = 32'(ERR_MAX);

   state_e                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [7:0]             timer_q;
   logic [DATA_BITS-1:0]   data_q;
   logic [DATA_BITS-1:0]   word_q;
   logic                   validPulse_q;
   logic                   errPulse_q;
   logic [31:0]            errCnt_q;

   logic                   serialBit;
   logic                   strobe;
   logic                   abort;
   logic                   dataOdd;
   logic                   parityBad_d;
   logic                   timeoutHit_d;
   logic [DATA_BITS-1:0]   dataIns_d;
   logic [31:0]            errCntInc_d;
   logic                   unusedUpper;

   assign serialBit   = bus.signal_0[0];
   assign strobe      = bus.signal_1[0];
   assign abort       = bus.signal_2[0];
   assign unusedUpper = ^{bus.signal_0[31:1], bus.signal_1[31:1], bus.signal_2[31:1]};

   parity_lut3 uParityLut (
      .d_i   (data_q),
      .odd_o (dataOdd)
   );

   // A good frame has even parity over all four bits, so the parity bit must
   // equal the odd-parity of the three stored data bits.
   assign parityBad_d  = dataOdd ^ serialBit;
   assign timeoutHit_d = (timer_q == TIMEOUT_W);
   assign errCntInc_d  = (errCnt_q >= ERR_MAX_W) ? errCnt_q : errCnt_q + 32'd1;

   always_comb begin
      dataIns_d          = data_q;
      dataIns_d[cnt_q]   = serialBit;
   end

   // Abort outranks everything; the timeout cycle doubles as a restart slot so
   // a strobe landing exactly on it is taken as d0 of a fresh frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         timer_q      <= '0;
         data_q       <= '0;
         word_q       <= '0;
         validPulse_q <= 1'b0;
         errPulse_q   <= 1'b0;
         errCnt_q     <= '0;
      end else begin
         validPulse_q <= 1'b0;
         errPulse_q   <= 1'b0;
         if (abort) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            timer_q  <= '0;
            errCnt_q <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (strobe) begin
                     data_q  <= {{(DATA_BITS-1){1'b0}}, serialBit};
                     cnt_q   <= CNT_W'(1);
                     timer_q <= '0;
                     state_q <= RECV;
                  end
               end
               RECV: begin
                  if (timeoutHit_d) begin
                     timer_q <= '0;
                     if (strobe) begin
                        data_q  <= {{(DATA_BITS-1){1'b0}}, serialBit};
                        cnt_q   <= CNT_W'(1);
                     end else begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                     end
                  end else if (strobe) begin
                     timer_q <= '0;
                     if (cnt_q == LAST_POS) begin
                        if (parityBad_d) begin
                           errPulse_q <= 1'b1;
                           errCnt_q   <= errCntInc_d;
                        end else begin
                           word_q       <= data_q;
                           validPulse_q <= 1'b1;
                        end
                        cnt_q   <= '0;
                        state_q <= IDLE;
                     end else begin
                        data_q <= dataIns_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                     end
                  end else begin
                     timer_q <= timer_q + 8'd1;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  timer_q <= '0;
               end
            endcase
         end
      end
   end

   assign bus.signal_A = {{(32-DATA_BITS){1'b0}}, word_q};
   assign bus.signal_B = {31'b0, validPulse_q};
   assign bus.signal_C = {31'b0, errPulse_q};
   assign bus.signal_D = errCnt_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker: a table of single-cycle vectors
// followed by hand-written timeout, saturation, abort and reset sequences.
module tb_parity_frame_checker;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   parity_frame_checker_if bus ();

   parity_frame_checker #(
      .TIMEOUT (8),
      .ERR_MAX (255)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int passCount   = 0;
   int totalChecks = 0;

   typedef struct {
      logic        strobe;
      logic        dataBit;
      logic        abort;
      logic [31:0] expA;
      logic [31:0] expB;
      logic [31:0] expC;
      logic [31:0] expD;
   } vector_t;

   vector_t vectors[29];

   // Drives one cycle of input (random upper bits) and returns just after the
   // edge that sampled it, so registered outputs reflect that edge.
   task automatic applyStimulus(input logic strobe, input logic dataBit, input logic abort);
      logic [31:0] r0, r1, r2;
      r0 = $urandom();
      r1 = $urandom();
      r2 = $urandom();
      bus.signal_0 = {r0[31:1], dataBit};
      bus.signal_1 = {r1[31:1], strobe};
      bus.signal_2 = {r2[31:1], abort};
      @(posedge clk);
      #1;
   endtask

   task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
      totalChecks++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   task automatic checkOutput(input string label, input logic [31:0] expA, input logic [31:0] expB,
                              input logic [31:0] expC, input logic [31:0] expD);
      checkField({label, ".A"}, bus.signal_A, expA);
      checkField({label, ".B"}, bus.signal_B, expB);
      checkField({label, ".C"}, bus.signal_C, expC);
      checkField({label, ".D"}, bus.signal_D, expD);
   endtask

   task automatic sendFrame(input logic [3:0] bits);
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, bits[k], 1'b0);
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, k[0], 1'b0);
   endtask

   initial begin
      // strobe, bit, abort, A, B, C, D  (frames listed in wire order d0,d1,d2,p)
      vectors[0]  = '{1, 1, 0, 0, 0, 0, 0};   // 1,0,1,0 -> good, word 5
      vectors[1]  = '{1, 0, 0, 0, 0, 0, 0};
      vectors[2]  = '{1, 1, 0, 0, 0, 0, 0};
      vectors[3]  = '{1, 0, 0, 5, 1, 0, 0};
      vectors[4]  = '{0, 1, 0, 5, 0, 0, 0};
      vectors[5]  = '{1, 1, 0, 5, 0, 0, 0};   // 1,1,0,1 -> bad
      vectors[6]  = '{1, 1, 0, 5, 0, 0, 0};
      vectors[7]  = '{1, 0, 0, 5, 0, 0, 0};
      vectors[8]  = '{1, 1, 0, 5, 0, 1, 1};
      vectors[9]  = '{0, 0, 0, 5, 0, 0, 1};
      vectors[10] = '{1, 1, 0, 5, 0, 0, 1};   // 1,1,1,1 with 1..3 idle gaps -> word 7
      vectors[11] = '{0, 0, 0, 5, 0, 0, 1};
      vectors[12] = '{1, 1, 0, 5, 0, 0, 1};
      vectors[13] = '{0, 0, 0, 5, 0, 0, 1};
      vectors[14] = '{0, 1, 0, 5, 0, 0, 1};
      vectors[15] = '{1, 1, 0, 5, 0, 0, 1};
      vectors[16] = '{0, 0, 0, 5, 0, 0, 1};
      vectors[17] = '{0, 1, 0, 5, 0, 0, 1};
      vectors[18] = '{0, 0, 0, 5, 0, 0, 1};
      vectors[19] = '{1, 1, 0, 7, 1, 0, 1};
      vectors[20] = '{1, 0, 0, 7, 0, 0, 1};   // back-to-back 0,1,1,0 -> word 6
      vectors[21] = '{1, 1, 0, 7, 0, 0, 1};
      vectors[22] = '{1, 1, 0, 7, 0, 0, 1};
      vectors[23] = '{1, 0, 0, 6, 1, 0, 1};
      vectors[24] = '{1, 1, 0, 6, 0, 0, 1};   // back-to-back 1,1,1,0 -> bad
      vectors[25] = '{1, 1, 0, 6, 0, 0, 1};
      vectors[26] = '{1, 1, 0, 6, 0, 0, 1};
      vectors[27] = '{1, 0, 0, 6, 0, 1, 2};
      vectors[28] = '{0, 1, 0, 6, 0, 0, 2};

      rst_n        = 1'b0;
      bus.signal_0 = '0;
      bus.signal_1 = '0;
      bus.signal_2 = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset", 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 29; i++) begin
         applyStimulus(vectors[i].strobe, vectors[i].dataBit, vectors[i].abort);
         checkOutput($sformatf("vec%0d", i), vectors[i].expA, vectors[i].expB,
                     vectors[i].expC, vectors[i].expD);
      end

      $display("[TB] timeout sequences");
      applyStimulus(1, 0, 0);
      applyStimulus(1, 1, 0);
      applyStimulus(1, 1, 0);
      idleCycles(8);
      checkOutput("to8.idle", 6, 0, 0, 2);
      sendFrame(4'b1100);
      checkOutput("to8.restart", 4, 1, 0, 2);

      applyStimulus(1, 1, 0);
      idleCycles(7);
      applyStimulus(1, 0, 0);
      applyStimulus(1, 1, 0);
      applyStimulus(1, 0, 0);
      checkOutput("to7.kept", 5, 1, 0, 2);

      applyStimulus(1, 1, 0);
      idleCycles(9);
      sendFrame(4'b0011);
      checkOutput("to9.dropped", 3, 1, 0, 2);

      $display("[TB] saturation and abort");
      for (int f = 0; f < 300; f++) sendFrame(4'b0001);
      checkOutput("sat.last", 3, 0, 1, 255);
      applyStimulus(0, 0, 0);
      checkOutput("sat.idle", 3, 0, 0, 255);
      applyStimulus(0, 0, 1);
      checkOutput("abort.clear", 3, 0, 0, 0);

      applyStimulus(1, 1, 0);
      applyStimulus(1, 1, 0);
      applyStimulus(1, 1, 0);
      applyStimulus(1, 1, 1);
      checkOutput("abort.onCompletion", 3, 0, 0, 0);
      sendFrame(4'b1001);
      checkOutput("abort.fresh", 1, 1, 0, 0);
      sendFrame(4'b0001);
      checkOutput("bad.afterAbort", 1, 0, 1, 1);

      $display("[TB] reset mid-frame");
      applyStimulus(1, 1, 0);
      applyStimulus(1, 1, 0);
      bus.signal_1 = '0;
      rst_n = 1'b0;
      #2;
      checkOutput("rst.mid", 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      sendFrame(4'b1010);
      checkOutput("rst.next", 2, 1, 0, 0);
      applyStimulus(0, 1, 0);
      checkOutput("rst.hold", 2, 0, 0, 0);

      $display("%0d/%0d checks passed", passCount, totalChecks);
      $finish;
   end

endmodule
